// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_chain
// Brief    : N-stage valid/ready register chain with bubble collapsing, per-stage
//            flush and forwarding/load-use lookup. Option: PIPE_CHAIN_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
   parameter int STAGES = 3,
   parameter int WIDTH  = 64,
   parameter int FWD_W  = 32,
   parameter int NQ     = 2,
   parameter int SELW   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_data,
   input  logic [4:0]          in_dst,
   input  logic                in_regwr,
   input  logic                in_pend,
   input  logic [STAGES-1:0]   pend_clr,
   input  logic [STAGES-1:0]   flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [4:0]          out_dst,
   output logic                out_regwr,
`ifdef PIPE_CHAIN_PERF_EN
   output logic [31:0]         perf_stall,
   output logic [31:0]         perf_kill,
`endif
   input  logic [NQ*5-1:0]     q_reg,
   output logic [NQ-1:0]       q_hit,
   output logic [NQ*SELW-1:0]  q_sel,
   output logic [NQ*FWD_W-1:0] q_data,
   output logic [NQ-1:0]       q_stall
);

   logic [STAGES-1:0] r_v;
   logic [STAGES-1:0] r_pend;
   logic [STAGES-1:0] r_regwr;
   logic [4:0]        r_dst  [STAGES];
   logic [WIDTH-1:0]  r_data [STAGES];

   logic [STAGES-1:0] w_ve;
   logic [STAGES:0]   w_rdy;
   logic [STAGES-1:0] w_src_live;
   logic [STAGES-1:0] w_src_pend;
   logic [STAGES-1:0] w_src_regwr;
   logic [4:0]        w_src_dst  [STAGES];
   logic [WIDTH-1:0]  w_src_data [STAGES];

   assign w_ve = r_v & ~flush;

   // A stage can take a new entry if it is empty (or being killed) or it drains this edge.
   always_comb begin
      w_rdy         = '0;
      w_rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         w_rdy[k] = ~w_ve[k] | w_rdy[k+1];
      end
   end

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_src
         if (k == 0) begin : g_head
            assign w_src_live[k]  = in_valid;
            assign w_src_pend[k]  = in_pend;
            assign w_src_regwr[k] = in_regwr;
            assign w_src_dst[k]   = in_dst;
            assign w_src_data[k]  = in_data;
         end else begin : g_link
            // A pending result that arrives on the move edge lands already cleared.
            assign w_src_live[k]  = w_ve[k-1];
            assign w_src_pend[k]  = r_pend[k-1] & ~pend_clr[k-1];
            assign w_src_regwr[k] = r_regwr[k-1];
            assign w_src_dst[k]   = r_dst[k-1];
            assign w_src_data[k]  = r_data[k-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_v     <= '0;
         r_pend  <= '0;
         r_regwr <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_dst[k]  <= '0;
            r_data[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_rdy[k]) begin
               r_v[k] <= w_src_live[k];
               if (w_src_live[k]) begin
                  r_pend[k]  <= w_src_pend[k];
                  r_regwr[k] <= w_src_regwr[k];
                  r_dst[k]   <= w_src_dst[k];
                  r_data[k]  <= w_src_data[k];
               end
            end else begin
               r_v[k]    <= w_ve[k];
               r_pend[k] <= r_pend[k] & ~pend_clr[k];
            end
         end
      end
   end

   assign in_ready  = w_rdy[0];
   assign out_valid = w_ve[STAGES-1];
   assign out_data  = r_data[STAGES-1];
   assign out_dst   = r_dst[STAGES-1];
   assign out_regwr = r_regwr[STAGES-1] & w_ve[STAGES-1];

   // Scan oldest to youngest so the youngest matching producer overrides.
   always_comb begin
      q_hit   = '0;
      q_sel   = '0;
      q_data  = '0;
      q_stall = '0;
      for (int i = 0; i < NQ; i++) begin
         for (int k = STAGES - 1; k >= 0; k--) begin
            if (w_ve[k] && r_regwr[k] && (r_dst[k] == q_reg[5*i +: 5]) &&
                (q_reg[5*i +: 5] != 5'd0)) begin
               q_hit[i]                 = 1'b1;
               q_sel[i*SELW +: SELW]    = SELW'(k + 1);
               q_data[i*FWD_W +: FWD_W] = r_data[k][FWD_W-1:0];
               q_stall[i]               = r_pend[k];
            end
         end
      end
   end

`ifdef PIPE_CHAIN_PERF_EN
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_kill;
   logic [32:0] w_kill_sum;

   always_comb begin
      w_kill_sum = {1'b0, r_perf_kill};
      for (int k = 0; k < STAGES; k++) begin
         w_kill_sum = w_kill_sum + {32'd0, r_v[k] & flush[k]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_stall <= '0;
         r_perf_kill  <= '0;
      end else begin
         if (in_valid && !w_rdy[0] && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
         r_perf_kill <= w_kill_sum[32] ? 32'hFFFF_FFFF : w_kill_sum[31:0];
      end
   end

   assign perf_stall = r_perf_stall;
   assign perf_kill  = r_perf_kill;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// Directed bench for pipe_stage_chain (default 3 stages) with an in-order scoreboard.
module tb_pipe_stage_chain;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [4:0]  in_dst;
   logic        in_regwr;
   logic        in_pend;
   logic [2:0]  pend_clr;
   logic [2:0]  flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [4:0]  out_dst;
   logic        out_regwr;
   logic [9:0]  q_reg;
   logic [1:0]  q_hit;
   logic [3:0]  q_sel;
   logic [63:0] q_data;
   logic [1:0]  q_stall;

   always #5 clk = ~clk;

   pipe_stage_chain dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dst    (in_dst),
      .in_regwr  (in_regwr),
      .in_pend   (in_pend),
      .pend_clr  (pend_clr),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_dst   (out_dst),
      .out_regwr (out_regwr),
      .q_reg     (q_reg),
      .q_hit     (q_hit),
      .q_sel     (q_sel),
      .q_data    (q_data),
      .q_stall   (q_stall)
   );

   typedef struct packed {
      logic [63:0] data;
      logic [4:0]  dst;
      logic        regwr;
   } sb_t;

   sb_t sb[$];
   int  n_checks = 0;
   int  n_err    = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Settle, score the handshakes of this cycle, then advance one edge.
   task automatic tick();
      sb_t e;
      #1;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 64'(out_valid), 64'd0);
         end else begin
            e = sb.pop_front();
            check("out_data", out_data, e.data);
            check("out_dst", 64'(out_dst), 64'(e.dst));
            check("out_regwr", 64'(out_regwr), 64'(e.regwr));
         end
      end
      if (in_valid && in_ready) begin
         sb.push_back(sb_t'{data: in_data, dst: in_dst, regwr: in_regwr});
      end
      @(posedge clk);
      #1;
   endtask

   function automatic void sb_kill(input logic [63:0] d);
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].data == d) begin
            sb.delete(i);
            break;
         end
      end
   endfunction

   task automatic drain(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 10 && sb.size() != 0; n++) tick();
      #1;
      check(tag, 64'(sb.size()), 64'd0);
      check({tag, "_idle"}, 64'(out_valid), 64'd0);
   endtask

   task automatic put(input logic [63:0] d, input logic [4:0] dst);
      in_valid = 1'b1;
      in_data  = d;
      in_dst   = dst;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_dst = '0; in_regwr = 1'b1;
      in_pend = 1'b0; pend_clr = '0; flush = '0; out_ready = 1'b0; q_reg = {5'd2, 5'd1};
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_out_dst", 64'(out_dst), 64'd0);
      check("rst_out_regwr", 64'(out_regwr), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_q_hit", 64'(q_hit), 64'd0);
      check("rst_q_sel", 64'(q_sel), 64'd0);
      check("rst_q_data", q_data, 64'd0);
      check("rst_q_stall", 64'(q_stall), 64'd0);
      rst = 1'b1;

      // Streaming: 3-stage latency, one result per cycle.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 64'(i + 1);
         in_dst  = 5'(i + 1);
         #1;
         check("t1_in_ready", 64'(in_ready), 64'd1);
         check("t1_out_valid", 64'(out_valid), 64'(i >= 3));
         tick();
      end
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t1_tail_valid", 64'(out_valid), 64'd1);
         tick();
      end
      drain("t1_drain");

      // Backpressure: full chain freezes, then releases in order.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data  = 64'h11 + 64'(i);
         in_dst   = 5'(i + 1);
         in_regwr = (i != 1);
         tick();
      end
      in_regwr = 1'b1;
      in_data  = 64'h14;
      in_dst   = 5'd4;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t2_in_ready", 64'(in_ready), 64'd0);
         check("t2_frozen", out_data, 64'h11);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("t2_release_ready", 64'(in_ready), 64'd1);
      tick();
      drain("t2_drain");

      // Bubble collapse: stage 1 empty while the output stalls.
      out_ready = 1'b0;
      put(64'h31, 5'd3);
      tick();
      tick();
      put(64'h32, 5'd4);
      in_valid = 1'b1;
      in_data  = 64'h33;
      in_dst   = 5'd6;
      #1;
      check("t3_in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      q_reg    = {5'd6, 5'd4};
      #1;
      check("t3_q_hit", 64'(q_hit), 64'h3);
      check("t3_q_sel", 64'(q_sel), 64'h6);
      check("t3_out_held", out_data, 64'h31);
      drain("t3_drain");

      // Flush of stage 1 hides it from queries and from the output.
      out_ready = 1'b0;
      put(64'h80, 5'd8);
      put(64'h70, 5'd7);
      flush = 3'b010;
      q_reg = {5'd7, 5'd8};
      #1;
      check("t4_q_hit", 64'(q_hit), 64'h2);
      check("t4_q_sel", 64'(q_sel), 64'h4);
      check("t4_q_data", q_data, 64'h0000_0070_0000_0000);
      sb_kill(64'h80);
      tick();
      flush = 3'b000;
      #1;
      check("t4_after_hit", 64'(q_hit[0]), 64'd0);
      drain("t4_drain");

      // Youngest producer wins; register 0 never matches.
      out_ready = 1'b0;
      put(64'hDEAD_BEEF_0000_00BB, 5'd5);
      tick();
      tick();
      put(64'hCAFE_0000_0000_00AA, 5'd5);
      q_reg = {5'd0, 5'd5};
      #1;
      check("t5_q_hit", 64'(q_hit), 64'h1);
      check("t5_q_sel", 64'(q_sel), 64'h1);
      check("t5_q_data", q_data, 64'h0000_0000_0000_00AA);
      drain("t5_drain");

      // Load-use: pending producer stalls until pend_clr on its move edge.
      out_ready = 1'b1;
      in_pend   = 1'b1;
      put(64'h99, 5'd9);
      in_pend = 1'b0;
      q_reg   = {5'd0, 5'd9};
      #1;
      check("t6_stall", 64'(q_stall), 64'h1);
      check("t6_sel0", 64'(q_sel), 64'h1);
      pend_clr = 3'b001;
      tick();
      pend_clr = 3'b000;
      #1;
      check("t6_unstall", 64'(q_stall), 64'h0);
      check("t6_sel1", 64'(q_sel), 64'h2);
      check("t6_hit", 64'(q_hit), 64'h1);
      drain("t6_drain");

      // Asynchronous reset in the middle of a stream.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 64'h61 + 64'(i);
         in_dst  = 5'(i + 1);
         tick();
      end
      in_valid = 1'b0;
      q_reg    = {5'd2, 5'd1};
      #2;
      rst = 1'b0;
      #1;
      check("rst2_out_valid", 64'(out_valid), 64'd0);
      check("rst2_out_data", out_data, 64'd0);
      check("rst2_in_ready", 64'(in_ready), 64'd1);
      check("rst2_q_hit", 64'(q_hit), 64'd0);
      check("rst2_q_sel", 64'(q_sel), 64'd0);
      check("rst2_q_data", q_data, 64'd0);
      check("rst2_q_stall", 64'(q_stall), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b1;
      put(64'h71, 5'd1);
      drain("rst2_recover");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
